// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and limits for the instruction prefetch unit
package ifu_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;
  // PC and exception fields are sized for AW up to 32
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic exc;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: synchronous FIFO of fetch entries with flush, simultaneous push/pop, count, empty, full
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  fetch_entry_t din,
  input  logic pop,
  output fetch_entry_t dout,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  // pointers and occupancy; flush empties the queue and wins over push and pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  // entry storage; reads are masked while empty so no reset is needed
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-based instruction prefetcher with redirect flush; IFU_PREFETCH_ADEL_EN enables misaligned-fetch AdEL entries
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic im_req,
  output logic [AW-1:0] im_addr,
  input  logic im_gnt,
  input  logic im_rvalid,
  input  logic [31:0] im_rdata,
  output logic F_valid,
  output logic [AW-1:0] F_PC,
  output logic [31:0] F_inStr,
  output logic F_excAdEL,
  input  logic D_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_W = DEPTH[PW:0];
  logic [AW-1:0] fetch_pc;
  logic [PW:0] in_flight, drop_cnt, q_count, in_flight_n;
  logic halt, credit, grant, rv_ok, live, misalign, adel_push;
  logic q_empty, q_full;
  logic [AW-1:0] pc_mem [DEPTH];
  logic [PW-1:0] pc_wr, pc_rd;
  fetch_entry_t q_din, head;
  // queue occupancy plus outstanding requests never exceeds DEPTH, so a response always has a slot
  assign credit = (q_count + in_flight) < DEPTH_W;
  assign im_req = !reset && credit && !redirect_valid && !halt && !misalign;
  assign im_addr = fetch_pc;
  assign grant = im_req && im_gnt;
  assign rv_ok = im_rvalid && in_flight != '0;
  assign live = rv_ok && !redirect_valid && drop_cnt == '0;
  assign in_flight_n = in_flight + {{PW{1'b0}}, grant} - {{PW{1'b0}}, rv_ok};
`ifdef IFU_PREFETCH_ADEL_EN
  // a misaligned PC becomes one exception entry once no live response is still owed
  assign misalign = |fetch_pc[1:0];
  assign adel_push = misalign && !halt && credit && !q_full && !redirect_valid && in_flight == drop_cnt;
`else
  assign misalign = 1'b0;
  assign adel_push = 1'b0;
`endif
  // entry pushed into the queue: either the returning instruction or an address-error marker
  always_comb begin
    q_din.pc = adel_push ? 32'(fetch_pc) : 32'(pc_mem[pc_rd]);
    q_din.instr = adel_push ? 32'h0 : im_rdata;
    q_din.exc = adel_push;
  end
  ifu_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(reset),
    .flush(redirect_valid),
    .push(live || adel_push),
    .din(q_din),
    .pop(D_ready),
    .dout(head),
    .count(q_count),
    .empty(q_empty),
    .full(q_full)
  );
  assign F_valid = !q_empty;
  assign F_PC = head.pc[AW-1:0];
  assign F_inStr = head.instr;
  // only exception entries ever carry exc, so without the feature this is constant 0
  assign F_excAdEL = head.exc;
  // fetch pointer, outstanding/drop counters, halt and PC-FIFO pointers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC[AW-1:0];
      in_flight <= '0;
      drop_cnt <= '0;
      halt <= 1'b0;
      pc_wr <= '0;
      pc_rd <= '0;
    end else begin
      in_flight <= in_flight_n;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        drop_cnt <= in_flight_n;
        halt <= 1'b0;
        pc_wr <= '0;
        pc_rd <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + AW'(4);
        if (rv_ok && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (adel_push) halt <= 1'b1;
        if (grant) pc_wr <= pc_wr + 1'b1;
        if (live) pc_rd <= pc_rd + 1'b1;
      end
    end
  // PC of each granted request, consumed in order by live responses
  always_ff @(posedge clk)
    if (grant) pc_mem[pc_wr] <= fetch_pc;
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed self-checking bench for ifu_prefetch with an in-order memory model
module tb_ifu_prefetch;
  logic clk = 0, reset = 0, redirect_valid = 0, im_gnt = 1, im_rvalid = 0, D_ready = 1;
  logic [31:0] redirect_pc = 0, im_rdata = 0;
  logic im_req, F_valid, F_excAdEL;
  logic [31:0] im_addr, F_PC, F_inStr;
  logic [31:0] pending [$];
  bit resp_on = 1, watch = 0;
  int errors = 0, checks = 0, grants = 0, stale = 0;
  bit found;

  ifu_prefetch dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .F_valid(F_valid), .F_PC(F_PC), .F_inStr(F_inStr), .F_excAdEL(F_excAdEL), .D_ready(D_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock; memory returns each granted word one cycle after grant, in order
  task automatic tick();
    bit g, rv;
    logic [31:0] a;
    #1;
    g = im_req && im_gnt;
    a = im_addr;
    rv = im_rvalid;
    @(posedge clk);
    #1;
    if (rv && pending.size() > 0) void'(pending.pop_front());
    if (g) begin
      pending.push_back(a);
      grants++;
    end
    im_rvalid = resp_on && pending.size() > 0;
    im_rdata = pending.size() > 0 ? ~pending[0] : 32'h0;
    if (watch && F_valid && F_PC < 32'h4000) stale++;
  endtask

  task automatic do_reset();
    reset = 1;
    redirect_valid = 0;
    im_rvalid = 0;
    pending.delete();
    tick();
    tick();
    reset = 0;
    grants = 0;
  endtask

  initial begin
    #1 reset = 1;
    #1;
    chk("rst_valid", F_valid, 0);
    chk("rst_pc", F_PC, 0);
    chk("rst_instr", F_inStr, 0);
    chk("rst_exc", F_excAdEL, 0);
    chk("rst_req", im_req, 0);

    // streaming: 1-cycle memory, decode always ready
    do_reset();
    #1;
    chk("first_req", im_req, 1);
    chk("first_addr", im_addr, 32'h3000);
    tick();
    chk("c1_valid", F_valid, 0);
    tick();
    chk("c2_valid", F_valid, 1);
    chk("c2_pc", F_PC, 32'h3000);
    chk("c2_instr", F_inStr, ~32'h3000);
    tick();
    chk("c3_pc", F_PC, 32'h3004);
    tick();
    chk("c4_pc", F_PC, 32'h3008);
    chk("c4_instr", F_inStr, ~32'h3008);

    // backpressure: exactly DEPTH grants, head holds
    D_ready = 0;
    do_reset();
    repeat (8) tick();
    chk("bp_grants", grants, 4);
    chk("bp_req", im_req, 0);
    chk("bp_valid", F_valid, 1);
    chk("bp_pc", F_PC, 32'h3000);
    D_ready = 1;
    #1;
    chk("bp_req_full", im_req, 0);
    tick();
    chk("bp_pop_pc", F_PC, 32'h3004);
    chk("bp_new_req", im_req, 1);
    chk("bp_new_addr", im_addr, 32'h3010);
    tick();
    chk("bp_grants2", grants, 5);

    // redirect with three requests outstanding
    resp_on = 0;
    do_reset();
    repeat (3) tick();
    im_gnt = 0;
    redirect_valid = 1;
    redirect_pc = 32'h4000;
    #1;
    chk("rd_req_low", im_req, 0);
    watch = 1;
    stale = 0;
    tick();
    redirect_valid = 0;
    im_gnt = 1;
    resp_on = 1;
    im_rvalid = pending.size() > 0;
    im_rdata = pending.size() > 0 ? ~pending[0] : 32'h0;
    #1;
    chk("rd_req", im_req, 1);
    chk("rd_addr", im_addr, 32'h4000);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      found = F_valid;
    end
    chk("rd_found", found, 1);
    chk("rd_pc", F_PC, 32'h4000);
    chk("rd_instr", F_inStr, ~32'h4000);
    tick();
    chk("rd_pc2", F_PC, 32'h4004);
    watch = 0;
    chk("rd_stale", stale, 0);

    // redirect coincident with a response and a pop
    do_reset();
    repeat (3) tick();
    chk("co_rvalid_pop", F_valid && im_rvalid, 1);
    redirect_valid = 1;
    redirect_pc = 32'h5000;
    tick();
    redirect_valid = 0;
    #1;
    chk("co_valid", F_valid, 0);
    chk("co_req", im_req, 1);
    chk("co_addr", im_addr, 32'h5000);
    tick();
    chk("co_valid2", F_valid, 0);
    tick();
    chk("co_pc", F_PC, 32'h5000);

    // misaligned redirect
    do_reset();
    im_gnt = 0;
    redirect_valid = 1;
    redirect_pc = 32'h3002;
    tick();
    redirect_valid = 0;
    im_gnt = 1;
    #1;
`ifdef IFU_PREFETCH_ADEL_EN
    chk("mis_req", im_req, 0);
    tick();
    chk("mis_valid", F_valid, 1);
    chk("mis_pc", F_PC, 32'h3002);
    chk("mis_exc", F_excAdEL, 1);
    chk("mis_instr", F_inStr, 0);
    repeat (3) tick();
    chk("mis_halt", im_req, 0);
    chk("mis_empty", F_valid, 0);
    redirect_valid = 1;
    redirect_pc = 32'h3008;
    tick();
    redirect_valid = 0;
    #1;
    chk("mis_resume", im_req, 1);
    chk("mis_resume_addr", im_addr, 32'h3008);
`else
    chk("mis_req", im_req, 1);
    chk("mis_addr", im_addr, 32'h3002);
    tick();
    tick();
    chk("mis_pc", F_PC, 32'h3002);
    chk("mis_exc", F_excAdEL, 0);
`endif

    // asynchronous reset mid-burst; responses during reset are ignored
    do_reset();
    repeat (4) tick();
    #2 reset = 1;
    #1;
    chk("ar_valid", F_valid, 0);
    chk("ar_pc", F_PC, 0);
    chk("ar_instr", F_inStr, 0);
    chk("ar_req", im_req, 0);
    im_rvalid = 1;
    im_rdata = 32'hdead_beef;
    tick();
    im_rvalid = 1;
    tick();
    pending.delete();
    im_rvalid = 0;
    reset = 0;
    #1;
    chk("ar_restart", im_req, 1);
    chk("ar_addr", im_addr, 32'h3000);
    tick();
    chk("ar_c1_valid", F_valid, 0);
    tick();
    chk("ar_pc2", F_PC, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
